// File: rtl/bus_master_arbiter.sv
// Two-master (CPU/DMA) to one-slave valid/ready bus arbiter with round-robin or
// fixed-CPU priority, one transaction (address then data phase) at a time.
module bus_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpuAddress,
  input  logic                  cpuIsWrite,
  input  logic                  cpuValid,
  output logic                  cpuReady,
  input  logic [DATA_WIDTH-1:0] cpuWriteData,
  input  logic                  cpuWriteValidData,
  output logic                  cpuWriteReadyData,
  output logic [DATA_WIDTH-1:0] cpuReadData,
  output logic                  cpuReadValidData,
  input  logic                  cpuReadReadyData,
  input  logic [ADDR_WIDTH-1:0] dmaAddress,
  input  logic                  dmaIsWrite,
  input  logic                  dmaValid,
  output logic                  dmaReady,
  input  logic [DATA_WIDTH-1:0] dmaWriteData,
  input  logic                  dmaWriteValidData,
  output logic                  dmaWriteReadyData,
  output logic [DATA_WIDTH-1:0] dmaReadData,
  output logic                  dmaReadValidData,
  input  logic                  dmaReadReadyData,
  output logic [ADDR_WIDTH-1:0] slvAddress,
  output logic                  slvIsWrite,
  output logic                  slvValid,
  input  logic                  slvReady,
  output logic [DATA_WIDTH-1:0] slvWriteData,
  output logic                  slvWriteValidData,
  input  logic                  slvWriteReadyData,
  input  logic [DATA_WIDTH-1:0] slvReadData,
  input  logic                  slvReadValidData,
  output logic                  slvReadReadyData,
  output logic                  grantOwner,
  output logic                  busBusy,
  output logic                  timeoutError
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_grant_owner;
  logic            w_next_owner;
  logic            r_last_granted;
  logic            w_next_last;
  logic            r_is_write;
  logic            w_next_is_write;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_next_count;
  logic            r_timeout_error;
  logic            w_next_timeout;

  logic [ADDR_WIDTH-1:0] w_own_addr;
  logic [DATA_WIDTH-1:0] w_own_wdata;
  logic                  w_own_valid;
  logic                  w_own_is_write;
  logic                  w_own_wvalid;
  logic                  w_own_rready;
  logic                  w_data_hs;
  logic                  w_in_addr;
  logic                  w_in_wr;
  logic                  w_in_rd;

  assign w_own_addr     = r_grant_owner ? dmaAddress        : cpuAddress;
  assign w_own_wdata    = r_grant_owner ? dmaWriteData      : cpuWriteData;
  assign w_own_valid    = r_grant_owner ? dmaValid          : cpuValid;
  assign w_own_is_write = r_grant_owner ? dmaIsWrite        : cpuIsWrite;
  assign w_own_wvalid   = r_grant_owner ? dmaWriteValidData : cpuWriteValidData;
  assign w_own_rready   = r_grant_owner ? dmaReadReadyData  : cpuReadReadyData;

  // Forwarding is suppressed while reset is high so no half handshake escapes.
  assign w_in_addr = (r_state == S_ADDR) && !reset;
  assign w_in_wr   = (r_state == S_DATA) &&  r_is_write && !reset;
  assign w_in_rd   = (r_state == S_DATA) && !r_is_write && !reset;

  assign w_data_hs = r_is_write ? (w_own_wvalid && slvWriteReadyData)
                                : (slvReadValidData && w_own_rready);

  assign slvAddress        = w_in_addr ? w_own_addr : '0;
  assign slvIsWrite        = w_in_addr & w_own_is_write;
  assign slvValid          = w_in_addr & w_own_valid;
  assign cpuReady          = w_in_addr & ~r_grant_owner & slvReady;
  assign dmaReady          = w_in_addr &  r_grant_owner & slvReady;

  assign slvWriteData      = w_in_wr ? w_own_wdata : '0;
  assign slvWriteValidData = w_in_wr & w_own_wvalid;
  assign cpuWriteReadyData = w_in_wr & ~r_grant_owner & slvWriteReadyData;
  assign dmaWriteReadyData = w_in_wr &  r_grant_owner & slvWriteReadyData;

  assign cpuReadData       = (w_in_rd && !r_grant_owner) ? slvReadData : '0;
  assign dmaReadData       = (w_in_rd &&  r_grant_owner) ? slvReadData : '0;
  assign cpuReadValidData  = w_in_rd & ~r_grant_owner & slvReadValidData;
  assign dmaReadValidData  = w_in_rd &  r_grant_owner & slvReadValidData;
  assign slvReadReadyData  = w_in_rd & w_own_rready;

  assign grantOwner   = r_grant_owner;
  assign busBusy      = (r_state != S_IDLE);
  assign timeoutError = r_timeout_error;

  // Next-state, arbitration and timeout decisions.
  always_comb begin
    w_next_state    = r_state;
    w_next_owner    = r_grant_owner;
    w_next_last     = r_last_granted;
    w_next_is_write = r_is_write;
    w_next_count    = r_count;
    w_next_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpuValid && dmaValid) begin
          w_next_state = S_ADDR;
          w_next_owner = (ROUND_ROBIN != 0) ? ~r_last_granted : 1'b0;
        end else if (cpuValid || dmaValid) begin
          w_next_state = S_ADDR;
          w_next_owner = dmaValid;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ADDR: begin
        // An abandoned request leaves the fairness history untouched.
        if (!w_own_valid) begin
          w_next_state = S_IDLE;
        end else if (slvReady) begin
          w_next_state    = S_DATA;
          w_next_is_write = w_own_is_write;
          w_next_count    = '0;
        end else begin
          w_next_state = S_ADDR;
        end
      end
      S_DATA: begin
        if (w_data_hs) begin
          w_next_state = S_IDLE;
          w_next_last  = r_grant_owner;
        end else if (r_count == TO_LAST) begin
          w_next_state   = S_IDLE;
          w_next_last    = r_grant_owner;
          w_next_timeout = 1'b1;
        end else begin
          w_next_count = r_count + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_grant_owner   <= 1'b0;
      r_last_granted  <= 1'b1;
      r_is_write      <= 1'b0;
      r_count         <= '0;
      r_timeout_error <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_grant_owner   <= w_next_owner;
      r_last_granted  <= w_next_last;
      r_is_write      <= w_next_is_write;
      r_count         <= w_next_count;
      r_timeout_error <= w_next_timeout;
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: one round-robin instance (timeout 8)
// and one fixed-priority instance share all inputs.
module tb_bus_master_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpuAddress, dmaAddress, cpuWriteData, dmaWriteData, slvReadData;
  logic        cpuIsWrite, cpuValid, cpuWriteValidData, cpuReadReadyData;
  logic        dmaIsWrite, dmaValid, dmaWriteValidData, dmaReadReadyData;
  logic        slvReady, slvWriteReadyData, slvReadValidData;

  logic        cpuReady, cpuWriteReadyData, cpuReadValidData;
  logic        dmaReady, dmaWriteReadyData, dmaReadValidData;
  logic [31:0] cpuReadData, dmaReadData, slvAddress, slvWriteData;
  logic        slvIsWrite, slvValid, slvWriteValidData, slvReadReadyData;
  logic        grantOwner, busBusy, timeoutError;

  logic        fp_cpuReady, fp_cpuWriteReadyData, fp_cpuReadValidData;
  logic        fp_dmaReady, fp_dmaWriteReadyData, fp_dmaReadValidData;
  logic [31:0] fp_cpuReadData, fp_dmaReadData, fp_slvAddress, fp_slvWriteData;
  logic        fp_slvIsWrite, fp_slvValid, fp_slvWriteValidData, fp_slvReadReadyData;
  logic        fp_grantOwner, fp_busBusy, fp_timeoutError;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bus_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) u_rr (
    .clock(clock), .reset(reset),
    .cpuAddress(cpuAddress), .cpuIsWrite(cpuIsWrite), .cpuValid(cpuValid), .cpuReady(cpuReady),
    .cpuWriteData(cpuWriteData), .cpuWriteValidData(cpuWriteValidData), .cpuWriteReadyData(cpuWriteReadyData),
    .cpuReadData(cpuReadData), .cpuReadValidData(cpuReadValidData), .cpuReadReadyData(cpuReadReadyData),
    .dmaAddress(dmaAddress), .dmaIsWrite(dmaIsWrite), .dmaValid(dmaValid), .dmaReady(dmaReady),
    .dmaWriteData(dmaWriteData), .dmaWriteValidData(dmaWriteValidData), .dmaWriteReadyData(dmaWriteReadyData),
    .dmaReadData(dmaReadData), .dmaReadValidData(dmaReadValidData), .dmaReadReadyData(dmaReadReadyData),
    .slvAddress(slvAddress), .slvIsWrite(slvIsWrite), .slvValid(slvValid), .slvReady(slvReady),
    .slvWriteData(slvWriteData), .slvWriteValidData(slvWriteValidData), .slvWriteReadyData(slvWriteReadyData),
    .slvReadData(slvReadData), .slvReadValidData(slvReadValidData), .slvReadReadyData(slvReadReadyData),
    .grantOwner(grantOwner), .busBusy(busBusy), .timeoutError(timeoutError)
  );

  bus_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) u_fp (
    .clock(clock), .reset(reset),
    .cpuAddress(cpuAddress), .cpuIsWrite(cpuIsWrite), .cpuValid(cpuValid), .cpuReady(fp_cpuReady),
    .cpuWriteData(cpuWriteData), .cpuWriteValidData(cpuWriteValidData), .cpuWriteReadyData(fp_cpuWriteReadyData),
    .cpuReadData(fp_cpuReadData), .cpuReadValidData(fp_cpuReadValidData), .cpuReadReadyData(cpuReadReadyData),
    .dmaAddress(dmaAddress), .dmaIsWrite(dmaIsWrite), .dmaValid(dmaValid), .dmaReady(fp_dmaReady),
    .dmaWriteData(dmaWriteData), .dmaWriteValidData(dmaWriteValidData), .dmaWriteReadyData(fp_dmaWriteReadyData),
    .dmaReadData(fp_dmaReadData), .dmaReadValidData(fp_dmaReadValidData), .dmaReadReadyData(dmaReadReadyData),
    .slvAddress(fp_slvAddress), .slvIsWrite(fp_slvIsWrite), .slvValid(fp_slvValid), .slvReady(slvReady),
    .slvWriteData(fp_slvWriteData), .slvWriteValidData(fp_slvWriteValidData), .slvWriteReadyData(slvWriteReadyData),
    .slvReadData(slvReadData), .slvReadValidData(slvReadValidData), .slvReadReadyData(fp_slvReadReadyData),
    .grantOwner(fp_grantOwner), .busBusy(fp_busBusy), .timeoutError(fp_timeoutError)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpuAddress = 32'h0; cpuIsWrite = 1'b0; cpuValid = 1'b0; cpuWriteData = 32'h0;
    cpuWriteValidData = 1'b0; cpuReadReadyData = 1'b0;
    dmaAddress = 32'h0; dmaIsWrite = 1'b0; dmaValid = 1'b0; dmaWriteData = 32'h0;
    dmaWriteValidData = 1'b0; dmaReadReadyData = 1'b0;
    slvReady = 1'b0; slvWriteReadyData = 1'b0; slvReadData = 32'h0; slvReadValidData = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busBusy); end
    n_checks++; if (grantOwner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %h want 0", grantOwner); end
    n_checks++; if (timeoutError !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %h want 0", timeoutError); end
    n_checks++; if ({slvValid, cpuReady, dmaReady, slvReadReadyData} !== 4'b0000) begin n_fail++; $display("FAIL reset_handshakes: got %b want 0000", {slvValid, cpuReady, dmaReady, slvReadReadyData}); end
    n_checks++; if (fp_busBusy !== 1'b0) begin n_fail++; $display("FAIL reset_fp_busy: got %h want 0", fp_busBusy); end
  endtask

  task automatic test_cpu_write();
    do_reset();
    cpuValid = 1'b1; cpuIsWrite = 1'b1; cpuAddress = 32'h1000_0004;
    cpuWriteData = 32'hDEAD_BEEF; cpuWriteValidData = 1'b1;
    slvReady = 1'b1; slvWriteReadyData = 1'b1;
    #1;
    n_checks++; if ({slvValid, busBusy} !== 2'b00) begin n_fail++; $display("FAIL wr_decision_cycle: got %b want 00", {slvValid, busBusy}); end
    tick();
    n_checks++; if (slvValid !== 1'b1 || slvAddress !== 32'h1000_0004 || slvIsWrite !== 1'b1) begin n_fail++; $display("FAIL wr_addr_fwd: got v=%h a=%h w=%h want 1 10000004 1", slvValid, slvAddress, slvIsWrite); end
    n_checks++; if ({cpuReady, dmaReady} !== 2'b10) begin n_fail++; $display("FAIL wr_addr_ready: got %b want 10", {cpuReady, dmaReady}); end
    tick();
    cpuValid = 1'b0;
    #1;
    n_checks++; if (slvWriteValidData !== 1'b1 || slvWriteData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_data_fwd: got v=%h d=%h want 1 deadbeef", slvWriteValidData, slvWriteData); end
    n_checks++; if ({cpuWriteReadyData, dmaWriteReadyData, cpuReady, slvValid} !== 4'b1000) begin n_fail++; $display("FAIL wr_data_ready: got %b want 1000", {cpuWriteReadyData, dmaWriteReadyData, cpuReady, slvValid}); end
    tick();
    cpuWriteValidData = 1'b0;
    #1;
    n_checks++; if ({busBusy, cpuWriteReadyData, slvWriteValidData} !== 3'b000) begin n_fail++; $display("FAIL wr_back_idle: got %b want 000", {busBusy, cpuWriteReadyData, slvWriteValidData}); end
  endtask

  task automatic test_arbitration();
    do_reset();
    cpuValid = 1'b1; dmaValid = 1'b1; cpuIsWrite = 1'b1; dmaIsWrite = 1'b1;
    cpuAddress = 32'h0000_000C; dmaAddress = 32'h0000_000D;
    cpuWriteValidData = 1'b1; dmaWriteValidData = 1'b1;
    slvReady = 1'b1; slvWriteReadyData = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic       exp_owner;
      logic [31:0] exp_addr;
      exp_owner = (k % 2 == 1) ? 1'b1 : 1'b0;
      exp_addr  = exp_owner ? 32'h0000_000D : 32'h0000_000C;
      tick();
      n_checks++; if (grantOwner !== exp_owner || busBusy !== 1'b1) begin n_fail++; $display("FAIL rr_grant[%0d]: got owner=%h busy=%h want %h 1", k, grantOwner, busBusy, exp_owner); end
      n_checks++; if (slvAddress !== exp_addr) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", k, slvAddress, exp_addr); end
      n_checks++; if (fp_grantOwner !== 1'b0 || fp_busBusy !== 1'b1) begin n_fail++; $display("FAIL fp_grant[%0d]: got owner=%h busy=%h want 0 1", k, fp_grantOwner, fp_busBusy); end
      tick();
      tick();
    end
  endtask

  task automatic test_dma_read();
    do_reset();
    dmaValid = 1'b1; dmaIsWrite = 1'b0; dmaAddress = 32'h1000_0020;
    dmaReadReadyData = 1'b1; cpuReadReadyData = 1'b1; slvReady = 1'b1;
    tick();
    n_checks++; if (grantOwner !== 1'b1 || slvAddress !== 32'h1000_0020 || slvIsWrite !== 1'b0) begin n_fail++; $display("FAIL rd_addr: got o=%h a=%h w=%h want 1 10000020 0", grantOwner, slvAddress, slvIsWrite); end
    n_checks++; if ({dmaReady, cpuReady} !== 2'b10) begin n_fail++; $display("FAIL rd_addr_ready: got %b want 10", {dmaReady, cpuReady}); end
    tick();
    dmaValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({dmaReadValidData, cpuReadValidData, slvReadReadyData, slvWriteValidData} !== 4'b0010) begin n_fail++; $display("FAIL rd_wait[%0d]: got %b want 0010", i, {dmaReadValidData, cpuReadValidData, slvReadReadyData, slvWriteValidData}); end
      tick();
    end
    slvReadValidData = 1'b1; slvReadData = 32'h1234_5678;
    #1;
    n_checks++; if (dmaReadData !== 32'h1234_5678 || dmaReadValidData !== 1'b1) begin n_fail++; $display("FAIL rd_data: got d=%h v=%h want 12345678 1", dmaReadData, dmaReadValidData); end
    n_checks++; if (cpuReadValidData !== 1'b0 || cpuReadData !== 32'h0) begin n_fail++; $display("FAIL rd_cpu_isolated: got v=%h d=%h want 0 0", cpuReadValidData, cpuReadData); end
    tick();
    n_checks++; if ({dmaReadValidData, busBusy} !== 2'b00) begin n_fail++; $display("FAIL rd_after: got %b want 00", {dmaReadValidData, busBusy}); end
    slvReadValidData = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    cpuValid = 1'b1; cpuIsWrite = 1'b1; cpuWriteValidData = 1'b1;
    dmaValid = 1'b1; dmaIsWrite = 1'b1; dmaWriteValidData = 1'b1;
    slvReady = 1'b1; slvWriteReadyData = 1'b0;
    tick();
    n_checks++; if (grantOwner !== 1'b0) begin n_fail++; $display("FAIL to_first_owner: got %h want 0", grantOwner); end
    tick();
    cpuValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if ({busBusy, timeoutError} !== 2'b10) begin n_fail++; $display("FAIL to_data[%0d]: got busy,err=%b want 10", i, {busBusy, timeoutError}); end
      tick();
    end
    n_checks++; if ({busBusy, timeoutError} !== 2'b01) begin n_fail++; $display("FAIL to_pulse: got busy,err=%b want 01", {busBusy, timeoutError}); end
    tick();
    n_checks++; if ({busBusy, timeoutError, grantOwner} !== 3'b101) begin n_fail++; $display("FAIL to_dma_granted: got %b want 101", {busBusy, timeoutError, grantOwner}); end
  endtask

  task automatic test_drop_valid();
    do_reset();
    cpuValid = 1'b1; cpuIsWrite = 1'b0; slvReady = 1'b0;
    tick();
    n_checks++; if ({slvValid, cpuReady} !== 2'b10) begin n_fail++; $display("FAIL drop_addr_wait: got %b want 10", {slvValid, cpuReady}); end
    tick();
    cpuValid = 1'b0;
    #1;
    n_checks++; if ({busBusy, slvValid, cpuReady} !== 3'b100) begin n_fail++; $display("FAIL drop_addr_gone: got %b want 100", {busBusy, slvValid, cpuReady}); end
    tick();
    n_checks++; if ({busBusy, slvReadReadyData} !== 2'b00) begin n_fail++; $display("FAIL drop_idle: got %b want 00", {busBusy, slvReadReadyData}); end
    cpuValid = 1'b1; dmaValid = 1'b1; slvReady = 1'b1;
    tick();
    n_checks++; if (grantOwner !== 1'b0 || busBusy !== 1'b1) begin n_fail++; $display("FAIL drop_next_tie: got owner=%h busy=%h want 0 1", grantOwner, busBusy); end
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    cpuValid = 1'b1; cpuIsWrite = 1'b1; cpuWriteValidData = 1'b1;
    slvReady = 1'b1; slvWriteReadyData = 1'b1;
    tick();
    tick();
    cpuValid = 1'b0;
    tick();
    cpuWriteValidData = 1'b0;
    cpuValid = 1'b1; cpuIsWrite = 1'b0; cpuReadReadyData = 1'b1;
    tick();
    tick();
    cpuValid = 1'b0;
    #1;
    n_checks++; if ({busBusy, grantOwner, slvReadReadyData} !== 3'b101) begin n_fail++; $display("FAIL rst_in_data: got %b want 101", {busBusy, grantOwner, slvReadReadyData}); end
    reset = 1'b1; slvReadValidData = 1'b1; slvReadData = 32'h0000_00AA;
    #1;
    n_checks++; if ({cpuReadValidData, slvReadReadyData} !== 2'b00) begin n_fail++; $display("FAIL rst_no_partial: got %b want 00", {cpuReadValidData, slvReadReadyData}); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if ({busBusy, slvValid, cpuReadValidData, slvReadReadyData, cpuReady, dmaReady} !== 6'b000000) begin n_fail++; $display("FAIL rst_after: got %b want 000000", {busBusy, slvValid, cpuReadValidData, slvReadReadyData, cpuReady, dmaReady}); end
    slvReadValidData = 1'b0; cpuValid = 1'b1; dmaValid = 1'b1;
    tick();
    n_checks++; if (grantOwner !== 1'b0 || busBusy !== 1'b1) begin n_fail++; $display("FAIL rst_first_tie: got owner=%h busy=%h want 0 1", grantOwner, busBusy); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_cpu_write();
    test_arbitration();
    test_dma_read();
    test_timeout();
    test_drop_valid();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
